// File: rtl/dds_sweep_sequencer.sv
// dds_sweep_sequencer: holds a host-loaded chirp sweep configuration and
// paces the AD9910 control stage with periodic io_update strobes, the ramp
// direction and the sweep width, while counting sweeps whose drover flag
// never arrived.
module dds_sweep_sequencer #(
    parameter int CLKNUM    = 2,
    parameter int UPD_WIDTH = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_pulse,
    input  logic [31:0] cfg_period,
    input  logic [1:0]  cfg_mode,
    input  logic [15:0] cfg_count,
    input  logic        start,
    input  logic        stop,
    input  logic        drover,
    output logic        io_update,
    output logic        sweep_sel,
    output logic [15:0] triger_pulse,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_cnt
);

    // Degenerate parameter sets fall back to the shortest legal strobe.
    localparam int          UPD_W    = ((UPD_WIDTH >= 2) && (CLKNUM > 0)) ? UPD_WIDTH : 2;
    localparam logic [31:0] UPD_LAST = 32'(UPD_W - 1);
    localparam logic [31:0] P_MIN    = 32'(UPD_W + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        UPDATE = 2'd2,
        DWELL  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] tmr_r;

    logic [15:0] sh_pulse_r;
    logic [31:0] sh_period_r;
    logic [1:0]  sh_mode_r;
    logic [15:0] sh_count_r;
    logic        cfg_loaded_r;

    logic [1:0]  act_mode_r;
    logic [15:0] act_count_r;
    logic [31:0] dwell_last_r;
    logic [15:0] sweep_cnt_r;
    logic        first_r;

    logic [1:0]  drv_sync_r;
    logic        drv_prev_r;
    logic        hit_r;

    logic        io_update_r;
    logic        sweep_sel_r;
    logic [15:0] triger_pulse_r;
    logic        busy_r;
    logic        done_r;
    logic        cfg_ready_r;
    logic [7:0]  err_cnt_r;

    logic        cfg_hs_s;
    logic        start_ok_s;
    logic        abort_s;
    logic        upd_exp_s;
    logic        dwell_exp_s;
    logic        final_s;
    logic        drv_rise_s;
    logic        upd_entry_s;
    logic        check_s;
    logic [31:0] p_eff_s;
    logic        io_update_s;
    logic        sweep_sel_s;
    logic        busy_s;
    logic        done_s;
    logic        cfg_ready_s;
    logic [7:0]  err_cnt_s;

    assign cfg_hs_s    = cfg_valid & cfg_ready_r;
    assign start_ok_s  = start & ~stop & cfg_loaded_r & (state_r == IDLE);
    assign abort_s     = stop & (state_r != IDLE);
    assign upd_exp_s   = (state_r == UPDATE) && (tmr_r == UPD_LAST);
    // After the final expiry the FSM lingers one cycle in DWELL while done
    // is presented, so done_r masks a second expiry.
    assign dwell_exp_s = (state_r == DWELL) && !done_r && (tmr_r == dwell_last_r);
    assign final_s     = (act_count_r != 16'd0) && (sweep_cnt_r == act_count_r);
    assign drv_rise_s  = drv_sync_r[1] & ~drv_prev_r;
    assign upd_entry_s = (state_r == PREP) && (state_next_s == UPDATE);
    // The previous sweep is judged at every PREP except the first of a burst,
    // and the last sweep is judged at its own DWELL expiry.
    assign check_s     = ((state_r == PREP) && !first_r) || (dwell_exp_s && final_s && !stop);

    assign cfg_ready    = cfg_ready_r;
    assign io_update    = io_update_r;
    assign sweep_sel    = sweep_sel_r;
    assign triger_pulse = triger_pulse_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_cnt      = err_cnt_r;

    // Clamp the repetition period so every sweep has at least one DWELL cycle.
    always_comb begin
        p_eff_s = sh_period_r;
        if (sh_period_r < P_MIN) begin
            p_eff_s = P_MIN;
        end else begin
            p_eff_s = sh_period_r;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; stop always wins over any pending transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_next_s = PREP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PREP: begin
                if (stop) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = UPDATE;
                end
            end
            UPDATE: begin
                if (stop) begin
                    state_next_s = IDLE;
                end else if (upd_exp_s) begin
                    state_next_s = DWELL;
                end else begin
                    state_next_s = UPDATE;
                end
            end
            DWELL: begin
                if (stop || done_r) begin
                    state_next_s = IDLE;
                end else if (dwell_exp_s) begin
                    if (final_s) begin
                        state_next_s = DWELL;
                    end else begin
                        state_next_s = PREP;
                    end
                end else begin
                    state_next_s = DWELL;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output logic: next values for the registered outputs.
    always_comb begin
        io_update_s = (state_next_s == UPDATE);
        busy_s      = (state_next_s != IDLE);
        cfg_ready_s = (state_next_s == IDLE);
        done_s      = (abort_s && !done_r) || (dwell_exp_s && final_s && !stop);
        sweep_sel_s = sweep_sel_r;
        err_cnt_s   = err_cnt_r;
        if (start_ok_s) begin
            if (sh_mode_r == 2'b00) begin
                sweep_sel_s = 1'b0;
            end else begin
                sweep_sel_s = 1'b1;
            end
        end else if ((state_r == DWELL) && (state_next_s == PREP)) begin
            case (act_mode_r)
                2'b00:   sweep_sel_s = 1'b0;
                2'b01:   sweep_sel_s = 1'b1;
                default: sweep_sel_s = ~sweep_sel_r;
            endcase
        end else begin
            sweep_sel_s = sweep_sel_r;
        end
        if (check_s && !hit_r && (err_cnt_r != 8'hFF)) begin
            err_cnt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            io_update_r <= 1'b0;
            sweep_sel_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
            err_cnt_r   <= 8'd0;
        end else begin
            io_update_r <= io_update_s;
            sweep_sel_r <= sweep_sel_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            cfg_ready_r <= cfg_ready_s;
            err_cnt_r   <= err_cnt_s;
        end
    end

    // Phase timer, restarted on every state change and parked in IDLE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmr_r <= 32'd0;
        end else if ((state_next_s != state_r) || (state_r == IDLE)) begin
            tmr_r <= 32'd0;
        end else begin
            tmr_r <= tmr_r + 32'd1;
        end
    end

    // Shadow configuration captured on the host handshake.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sh_pulse_r   <= 16'd0;
            sh_period_r  <= 32'd0;
            sh_mode_r    <= 2'b00;
            sh_count_r   <= 16'd0;
            cfg_loaded_r <= 1'b0;
        end else if (cfg_hs_s) begin
            sh_pulse_r   <= cfg_pulse;
            sh_period_r  <= cfg_period;
            sh_mode_r    <= cfg_mode;
            sh_count_r   <= cfg_count;
            cfg_loaded_r <= 1'b1;
        end
    end

    // Active configuration, frozen for the whole burst.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            act_mode_r     <= 2'b00;
            act_count_r    <= 16'd0;
            dwell_last_r   <= 32'd0;
            triger_pulse_r <= 16'd0;
        end else if (start_ok_s) begin
            act_mode_r     <= sh_mode_r;
            act_count_r    <= sh_count_r;
            dwell_last_r   <= p_eff_s - P_MIN;
            triger_pulse_r <= sh_pulse_r;
        end
    end

    // Sweep counter and first-sweep marker; the counter wraps when continuous.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sweep_cnt_r <= 16'd0;
            first_r     <= 1'b0;
        end else if (start_ok_s) begin
            sweep_cnt_r <= 16'd0;
            first_r     <= 1'b1;
        end else begin
            if (upd_entry_s) begin
                sweep_cnt_r <= sweep_cnt_r + 16'd1;
            end
            if (state_r == PREP) begin
                first_r <= 1'b0;
            end
        end
    end

    // drover synchroniser and rise-detect history.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            drv_sync_r <= 2'b00;
            drv_prev_r <= 1'b0;
        end else begin
            drv_sync_r <= {drv_sync_r[0], drover};
            drv_prev_r <= drv_sync_r[1];
        end
    end

    // Per-sweep drover hit flag, armed at UPDATE entry.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hit_r <= 1'b0;
        end else if (upd_entry_s) begin
            hit_r <= 1'b0;
        end else if (drv_rise_s && ((state_r == UPDATE) || (state_r == DWELL))) begin
            hit_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// Scoreboard bench for dds_sweep_sequencer: stimulus queues expected strobe
// rises, done pulses and state probes; one monitor compares them as they occur.
module tb_dds_sweep_sequencer;

    localparam int UPD_WIDTH = 4;
    localparam int EV_RISE   = 1;
    localparam int EV_DONE   = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_pulse = 16'd0;
    logic [31:0] cfg_period = 32'd0;
    logic [1:0]  cfg_mode = 2'b00;
    logic [15:0] cfg_count = 16'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        drover = 1'b0;
    logic        io_update;
    logic        sweep_sel;
    logic [15:0] triger_pulse;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;

    typedef struct {
        int          kind;
        int          at;
        logic        sel;
        logic [15:0] pulse;
        logic [7:0]  err;
    } ev_t;

    typedef struct {
        int   at;
        logic busy;
        logic ready;
        logic io;
    } probe_t;

    ev_t    exp_q[$];
    probe_t probe_q[$];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     rst_req_cnt = 0;
    bit     width_en = 1'b1;
    bit     end_req = 1'b0;

    dds_sweep_sequencer #(.CLKNUM(2), .UPD_WIDTH(UPD_WIDTH)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_pulse    (cfg_pulse),
        .cfg_period   (cfg_period),
        .cfg_mode     (cfg_mode),
        .cfg_count    (cfg_count),
        .start        (start),
        .stop         (stop),
        .drover       (drover),
        .io_update    (io_update),
        .sweep_sel    (sweep_sel),
        .triger_pulse (triger_pulse),
        .busy         (busy),
        .done         (done),
        .err_cnt      (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic exp_rise(input int at, input logic sel, input logic [15:0] p);
        ev_t e;
        e.kind = EV_RISE; e.at = at; e.sel = sel; e.pulse = p; e.err = 8'd0;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input int at, input logic [7:0] err);
        ev_t e;
        e.kind = EV_DONE; e.at = at; e.sel = 1'b0; e.pulse = 16'd0; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic probe(input int at, input logic b, input logic r, input logic io);
        probe_t p;
        p.at = at; p.busy = b; p.ready = r; p.io = io;
        probe_q.push_back(p);
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 2000 && cyc < c; i++) @(negedge sys_clk);
    endtask

    task automatic load_cfg(input logic [15:0] p, input logic [31:0] per,
                            input logic [1:0] m, input logic [15:0] c);
        @(negedge sys_clk);
        cfg_pulse = p; cfg_period = per; cfg_mode = m; cfg_count = c;
        cfg_valid = 1'b1;
        @(negedge sys_clk);
        cfg_valid = 1'b0;
    endtask

    // Monitor: the only process that makes comparisons and steps the counters.
    initial begin : monitor
        int     rst_seen;
        int     hi_cnt;
        logic   prev_io;
        ev_t    e;
        probe_t p;
        rst_seen = 0;
        hi_cnt   = 0;
        prev_io  = 1'b0;
        forever begin
            @(negedge sys_clk or rst_req_cnt);
            if (rst_req_cnt != rst_seen) begin
                rst_seen = rst_req_cnt;
                checks++;
                if (io_update !== 1'b0 || sweep_sel !== 1'b0 || triger_pulse !== 16'd0 ||
                    busy !== 1'b0 || done !== 1'b0 || err_cnt !== 8'd0 || cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_values: got io=%b sel=%b pulse=%0d busy=%b done=%b err=%0d ready=%b, want 0 0 0 0 0 0 1",
                             io_update, sweep_sel, triger_pulse, busy, done, err_cnt, cfg_ready);
                end
            end else begin
                while (probe_q.size() > 0 && probe_q[0].at <= cyc) begin
                    p = probe_q.pop_front();
                    checks++;
                    if (p.at != cyc || busy !== p.busy || cfg_ready !== p.ready || io_update !== p.io) begin
                        errors++;
                        $display("FAIL probe@%0d: at cycle %0d got busy=%b ready=%b io=%b, want busy=%b ready=%b io=%b",
                                 p.at, cyc, busy, cfg_ready, io_update, p.busy, p.ready, p.io);
                    end
                end
                if (io_update && !prev_io) begin
                    hi_cnt = 1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rise_unexpected: io_update rose at cycle %0d, want no rise", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != EV_RISE || e.at != cyc || sweep_sel !== e.sel || triger_pulse !== e.pulse) begin
                            errors++;
                            $display("FAIL rise: got cycle=%0d sel=%b pulse=%0d, want kind=%0d cycle=%0d sel=%b pulse=%0d",
                                     cyc, sweep_sel, triger_pulse, e.kind, e.at, e.sel, e.pulse);
                        end
                    end
                end else if (io_update) begin
                    hi_cnt++;
                end else if (prev_io && width_en) begin
                    checks++;
                    if (hi_cnt != UPD_WIDTH) begin
                        errors++;
                        $display("FAIL io_width: got %0d cycles high, want %0d", hi_cnt, UPD_WIDTH);
                    end
                end
                prev_io = io_update;
                if (done) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected: done high at cycle %0d, want low", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != EV_DONE || e.at != cyc || err_cnt !== e.err) begin
                            errors++;
                            $display("FAIL done: got cycle=%0d err_cnt=%0d, want kind=%0d cycle=%0d err_cnt=%0d",
                                     cyc, err_cnt, e.kind, e.at, e.err);
                        end
                    end
                end
                if (end_req) begin
                    checks++;
                    if (exp_q.size() != 0 || probe_q.size() != 0) begin
                        errors++;
                        $display("FAIL leftover: got %0d events and %0d probes pending, want 0 and 0",
                                 exp_q.size(), probe_q.size());
                    end
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int e;
        int s;
        @(negedge sys_clk);
        #2 rst_req_cnt = rst_req_cnt + 1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;

        // start before any config: ignored
        @(negedge sys_clk);
        s = cyc; start = 1'b1;
        probe(s + 1, 1'b0, 1'b1, 1'b0);
        probe(s + 2, 1'b0, 1'b1, 1'b0);
        @(negedge sys_clk); start = 1'b0;
        @(negedge sys_clk);

        // start and stop together in IDLE: stop wins
        load_cfg(16'd1000, 32'd20, 2'b10, 16'd3);
        s = cyc; start = 1'b1; stop = 1'b1;
        probe(s + 1, 1'b0, 1'b1, 1'b0);
        probe(s + 2, 1'b0, 1'b1, 1'b0);
        @(negedge sys_clk); start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge sys_clk);

        // alternate burst of 3, drover seen every sweep
        e = cyc + 1; start = 1'b1;
        exp_rise(e + 1, 1'b1, 16'd1000);
        exp_rise(e + 21, 1'b0, 16'd1000);
        exp_rise(e + 41, 1'b1, 16'd1000);
        exp_done(e + 60, 8'd0);
        probe(e, 1'b1, 1'b0, 1'b0);
        probe(e + 60, 1'b1, 1'b0, 1'b0);
        probe(e + 61, 1'b0, 1'b1, 1'b0);
        @(negedge sys_clk); start = 1'b0;
        foreach (exp_q[i]) begin end
        wait_cyc(e + 6);  drover = 1'b1; @(negedge sys_clk); @(negedge sys_clk); drover = 1'b0;
        wait_cyc(e + 26); drover = 1'b1; @(negedge sys_clk); @(negedge sys_clk); drover = 1'b0;
        wait_cyc(e + 46); drover = 1'b1; @(negedge sys_clk); @(negedge sys_clk); drover = 1'b0;
        wait_cyc(e + 63);

        // same burst, drover never arrives: three misses
        e = cyc + 1; start = 1'b1;
        exp_rise(e + 1, 1'b1, 16'd1000);
        exp_rise(e + 21, 1'b0, 16'd1000);
        exp_rise(e + 41, 1'b1, 16'd1000);
        exp_done(e + 60, 8'd3);
        @(negedge sys_clk); start = 1'b0;
        wait_cyc(e + 63);

        // period 3 clamps to 6, up-only, two sweeps
        load_cfg(16'd1000, 32'd3, 2'b00, 16'd2);
        e = cyc + 1; start = 1'b1;
        exp_rise(e + 1, 1'b0, 16'd1000);
        exp_rise(e + 7, 1'b0, 16'd1000);
        exp_done(e + 12, 8'd5);
        probe(e + 13, 1'b0, 1'b1, 1'b0);
        @(negedge sys_clk); start = 1'b0;
        wait_cyc(e + 15);

        // continuous down-only, aborted in DWELL of the third sweep
        load_cfg(16'd777, 32'd10, 2'b01, 16'd0);
        e = cyc + 1; start = 1'b1;
        exp_rise(e + 1, 1'b1, 16'd777);
        exp_rise(e + 11, 1'b1, 16'd777);
        exp_rise(e + 21, 1'b1, 16'd777);
        exp_done(e + 27, 8'd7);
        probe(e + 26, 1'b1, 1'b0, 1'b0);
        probe(e + 27, 1'b0, 1'b1, 1'b0);
        probe(e + 28, 1'b0, 1'b1, 1'b0);
        @(negedge sys_clk); start = 1'b0;
        wait_cyc(e + 26); stop = 1'b1;
        @(negedge sys_clk); stop = 1'b0;
        wait_cyc(e + 34);

        // config offered mid-burst is refused; shadow and active unchanged
        load_cfg(16'd1000, 32'd20, 2'b10, 16'd2);
        e = cyc + 1; start = 1'b1;
        exp_rise(e + 1, 1'b1, 16'd1000);
        exp_rise(e + 21, 1'b0, 16'd1000);
        exp_done(e + 40, 8'd9);
        probe(e + 10, 1'b1, 1'b0, 1'b0);
        @(negedge sys_clk); start = 1'b0;
        wait_cyc(e + 9);
        cfg_pulse = 16'd555; cfg_period = 32'd8; cfg_mode = 2'b00; cfg_count = 16'd1;
        cfg_valid = 1'b1;
        @(negedge sys_clk); @(negedge sys_clk); cfg_valid = 1'b0;
        wait_cyc(e + 42);
        e = cyc + 1; start = 1'b1;
        exp_rise(e + 1, 1'b1, 16'd1000);
        exp_rise(e + 21, 1'b0, 16'd1000);
        exp_done(e + 40, 8'd11);
        @(negedge sys_clk); start = 1'b0;
        wait_cyc(e + 42);

        // asynchronous reset in the middle of UPDATE
        e = cyc + 1; start = 1'b1;
        exp_rise(e + 1, 1'b1, 16'd1000);
        @(negedge sys_clk); start = 1'b0;
        wait_cyc(e + 2);
        width_en = 1'b0;
        #2 sys_rst = 1'b1;
        #1 rst_req_cnt = rst_req_cnt + 1;
        @(negedge sys_clk); sys_rst = 1'b0;
        @(negedge sys_clk); width_en = 1'b1;

        // reset cleared cfg_loaded: start is ignored again
        s = cyc; start = 1'b1;
        probe(s + 1, 1'b0, 1'b1, 1'b0);
        @(negedge sys_clk); start = 1'b0;
        wait_cyc(s + 4);

        for (int i = 0; i < 100 && (exp_q.size() != 0 || probe_q.size() != 0); i++) @(negedge sys_clk);
        end_req = 1'b1;
    end

endmodule

// File: doc/dds_sweep_sequencer.md
# dds_sweep_sequencer

Upstream sequencer for the AD9910 chirp path. Holds a host-loaded sweep configuration and issues the periodic `io_update` strobes, `sweep_sel` direction and `triger_pulse` width consumed by the DDS control stage. It also watches the DDS `drover` flag, counting sweeps that never reach the end of their ramp.

## Interface
- `CLKNUM`, 2: clock period in ns (500 MHz); informational, passed alongside `triger_pulse`.
- `UPD_WIDTH`, 4: `io_update` high time in clock cycles (≥2).
- `sys_clk`  in  1  system clock, 500 MHz; single clock domain.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `cfg_valid`  in  1  host config valid.
- `cfg_ready`  out  1  config accepted when `cfg_valid & cfg_ready`; equals (state == IDLE).
- `cfg_pulse`  in  16  sweep width in ns.
- `cfg_period`  in  32  `io_update` repetition period in cycles.
- `cfg_mode`  in  2  00 up-only (sel 0), 01 down-only (sel 1), 10/11 alternate, starting at 1.
- `cfg_count`  in  16  sweeps per burst; 0 = continuous.
- `start`  in  1  begin burst (single-cycle pulse).
- `stop`  in  1  abort burst (single-cycle pulse).
- `drover`  in  1  DDS digital-ramp-over flag, asynchronous to `sys_clk`.
- `io_update`  out  1  DDS update strobe.
- `sweep_sel`  out  1  ramp direction to the control stage.
- `triger_pulse`  out  16  active sweep width in ns.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at the end or abort of a burst.
- `err_cnt`  out  8  count of missed-`drover` sweeps, saturating.

## Operation
- Shadow registers capture `cfg_*` on handshake and set `cfg_loaded`. `cfg_loaded` is cleared only by reset.
- `start` in IDLE with `cfg_loaded` = 1 does the following:
  - copies the shadow registers to the active registers;
  - drives `triger_pulse` from the active `cfg_pulse`;
  - goes to PREP.
- `start` is ignored if `cfg_loaded` = 0 or the block is not in IDLE.
- Active period P = max(`cfg_period`, UPD_WIDTH+2).
- FSM states are IDLE, PREP, UPDATE and DWELL.
  - PREP lasts 1 cycle. It sets `sweep_sel` per mode, checks the previous sweep's `drover` hit, then goes to UPDATE.
  - UPDATE raises `io_update` for UPD_WIDTH cycles and increments the sweep counter on entry. It then goes to DWELL.
  - DWELL lasts P−UPD_WIDTH−1 cycles. At expiry it goes to PREP, unless `cfg_count` ≠ 0 and the sweep counter equals `cfg_count`. In that case it runs the final `drover` check, pulses `done` and goes to IDLE.
- Alternate mode: the first sweep of each burst has `sweep_sel` = 1, then the value toggles every PREP. `sweep_sel` holds its value in IDLE.
- `drover` handling:
  - `drover` is synchronised through 2 flops, then rise-detected.
  - The hit flag clears on UPDATE entry and sets on any synchronised rising edge up to the end of DWELL.
  - The check at PREP or burst end increments `err_cnt` if hit = 0. `err_cnt` saturates at 255. The check is skipped for the first PREP of a burst.
- `stop` in PREP, UPDATE or DWELL:
  - the next state is IDLE;
  - `io_update` is 0 from the next cycle;
  - `done` pulses;
  - no `drover` check is made for the aborted sweep.
- `start` and `stop` in the same cycle while in IDLE: `stop` wins and the block stays in IDLE.
- `cfg_valid` outside IDLE is not accepted (`cfg_ready` = 0). The active configuration never changes mid-burst.
- Sweep counter is 16 bits. In continuous mode it wraps silently.

## Timing
- Reset values:
  - `io_update` 0, `sweep_sel` 0, `triger_pulse` 0, `busy` 0, `done` 0, `err_cnt` 0;
  - state IDLE, so `cfg_ready` 1;
  - `cfg_loaded` 0, hit 0, counters 0.
- Reset is asynchronous. Asserting it mid-burst drops `io_update` immediately, with no `done` pulse.
- `start` sampled at cycle N:
  - PREP at N+1;
  - `io_update` registered high from N+2 through N+1+UPD_WIDTH;
  - `busy` high from N+1.
- `sweep_sel` and `triger_pulse` are stable at least 1 cycle before each `io_update` rise.
- Consecutive `io_update` rising edges are exactly P cycles apart.
- Burst with `cfg_count` = C:
  - last `io_update` rise at N+2+(C−1)·P;
  - `done` at N+1+C·P;
  - IDLE and `busy` = 0 at N+2+C·P.
- `drover` latency from pin to hit flag is 3 cycles. A rise within the last 3 cycles of DWELL can be missed by the check, and that is accepted.

## Test plan
- Load pulse=1000, period=20, mode=10, count=3 (UPD_WIDTH=4), `start`:
  - `io_update` rises at start+2, +22, +42, each high 4 cycles;
  - `sweep_sel` = 1, 0, 1;
  - `triger_pulse` = 1000;
  - `done` at start+61.
- Same config with `drover` pulsed 5 cycles after each `io_update` rise: `err_cnt` stays 0. With `drover` never pulsed: `err_cnt` = 3 after `done`.
- period=3 → clamped to P=6; rises 6 cycles apart. `start` before any config load, or `start`+`stop` together in IDLE: `busy` stays 0.
- count=0, mode=01: continuous, `sweep_sel` always 1. `stop` mid-DWELL: `io_update` 0 next cycle, `done` pulses once, IDLE the cycle after.
- `cfg_valid` asserted mid-burst: `cfg_ready` = 0 and the active config is unchanged. Async `sys_rst` mid-UPDATE: all outputs return to reset values without waiting for a clock edge.
